// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the programmable clock divider
// No ports: provides DIV_MIN and half_hi() to the divider files.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  // Number of posedge cycles pos_q is held high per period of N cycles.
  // Odd N gets the extra cycle; the negedge flop trims it back to N/2.
  function automatic int unsigned half_hi(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - divisor request handshake bundle for clk_div_prog
// div_in     requested divisor (master -> slave)
// div_valid  div_in valid (master -> slave)
// div_ready  no divisor pending, transfer possible (slave -> master)
// div_err    one-cycle pulse when an offered divisor below DIV_MIN is rejected (slave -> master)
interface clk_div_prog_if #(
  parameter int W = 8
) ();

  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic         div_err;

  modport master (output div_in, output div_valid, input div_ready, input div_err);
  modport slave  (input div_in, input div_valid, output div_ready, output div_err);

endinterface

// File: rtl/clk_div_phase.sv
// rtl/clk_div_phase.sv - output phase flops and odd/even combine for clk_div_prog
// clk_in   source clock
// rst      synchronous active-high reset
// pos_d    next-cycle high request for the divided clock
// odd_d    divisor in effect for pos_d is odd
// clk_out  divided clock
module clk_div_phase (
  input  logic clk_in,
  input  logic rst,
  input  logic pos_d,
  input  logic odd_d,
  output logic clk_out
);

  logic pos_q;
  logic neg_q;
  logic odd_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pos_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      odd_q <= odd_d;
    end
  end

  // neg_q captures the same request half a cycle before pos_q does, so
  // in the AND it is already high when pos_q rises (rise stays on the
  // posedge) and falls half a cycle before pos_q (trimming odd N to N/2).
  always_ff @(negedge clk_in) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_d;
    end
  end

  assign clk_out = odd_q ? (pos_q & neg_q) : pos_q;

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable 50%-duty integer clock divider
// clk_in   source clock
// rst      synchronous active-high reset
// en       run enable, sampled at period boundaries
// div_if   divisor request handshake (slave side)
// clk_out  divided clock
// tick     one-cycle pulse on the first cycle of each output period
// cur_div  divisor currently in effect
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W       = 8,
  parameter int RST_DIV = 7
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en,
  clk_div_prog_if.slave div_if,
  output logic          clk_out,
  output logic          tick,
  output logic [W-1:0]  cur_div
);

  logic [W-1:0] cnt;
  logic [W-1:0] pend_div;
  logic         pend_v;
  logic         run;
  logic         err_q;
  logic         boundary;
  logic         accept;
  logic         pos_d;

  // While stopped every cycle is a boundary, so a restart or a pending
  // divisor takes effect on the very next edge.
  assign boundary = !run || (cnt == cur_div - W'(1));
  assign accept   = div_if.div_valid && !pend_v;
  assign pos_d    = run && (32'(cnt) < half_hi(32'(cur_div)));

  assign div_if.div_ready = !pend_v;
  assign div_if.div_err   = err_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt      <= '0;
      cur_div  <= W'(RST_DIV);
      pend_div <= '0;
      pend_v   <= 1'b0;
      run      <= 1'b0;
      err_q    <= 1'b0;
      tick     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // Registered from the same state as pos_d so tick lines up with the rising edge.
      tick  <= run && (cnt == '0);

      if (boundary) begin
        cnt <= '0;
        run <= en;
        if (pend_v) begin
          cur_div <= pend_div;
          pend_v  <= 1'b0;
        end
      end else begin
        cnt <= cnt + W'(1);
      end

      // accept implies pend_v is clear, so it never collides with the
      // boundary clear above; a same-cycle transfer waits for the next boundary.
      if (accept) begin
        if (32'(div_if.div_in) >= DIV_MIN) begin
          pend_div <= div_if.div_in;
          pend_v   <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  clk_div_phase u_phase (
    .clk_in  (clk_in),
    .rst     (rst),
    .pos_d   (pos_d),
    .odd_d   (cur_div[0]),
    .clk_out (clk_out)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard testbench for clk_div_prog
module tb_clk_div_prog;

  localparam int W       = 8;
  localparam int RST_DIV = 7;

  logic         clk_in = 1'b0;
  logic         rst    = 1'b1;
  logic         en     = 1'b0;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] cur_div;

  clk_div_prog_if #(.W(W)) div_if ();

  clk_div_prog #(.W(W), .RST_DIV(RST_DIV)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_if  (div_if),
    .clk_out (clk_out),
    .tick    (tick),
    .cur_div (cur_div)
  );

  always #5 clk_in = ~clk_in;

  // Expected period starts: edge on which tick/rise is seen, and the period's divisor.
  typedef struct {
    int e;
    int n;
  } period_t;

  period_t tq[$];
  int      eq[$];

  int edge_n     = 0;
  int m_cur      = RST_DIV;
  int m_pend     = 0;
  int m_bound_at = 0;
  bit m_pend_v   = 1'b0;
  bit m_run      = 1'b0;
  int hc_left    = 0;

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
  endfunction

  // Period-level reference: each period of N starting on a boundary edge
  // yields a tick and rising edge one edge later with N half-cycles high.
  task automatic model_edge();
    bit acc;
    edge_n++;
    if (rst) begin
      m_cur    = RST_DIV;
      m_pend_v = 1'b0;
      m_run    = 1'b0;
      tq.delete();
      eq.delete();
    end else begin
      acc = div_if.div_valid && !m_pend_v;
      if (!m_run || edge_n == m_bound_at) begin
        if (m_pend_v) begin
          m_cur    = m_pend;
          m_pend_v = 1'b0;
        end
        m_run = en;
        if (en) begin
          tq.push_back('{edge_n + 1, m_cur});
          m_bound_at = edge_n + m_cur;
        end
      end
      if (acc) begin
        if (int'(div_if.div_in) >= 2) begin
          m_pend   = int'(div_if.div_in);
          m_pend_v = 1'b1;
        end else begin
          eq.push_back(edge_n);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    model_edge();
  end

  task automatic sample(input bit at_pos);
    bit exp_tick;
    bit exp_err;
    if (at_pos) begin
      if (rst) hc_left = 0;
      exp_tick = (tq.size() > 0) && (tq[0].e == edge_n);
      if (exp_tick) begin
        hc_left = tq[0].n;
        void'(tq.pop_front());
      end
      chk("tick", int'(tick), int'(exp_tick));
      exp_err = (eq.size() > 0) && (eq[0] == edge_n);
      if (exp_err) void'(eq.pop_front());
      chk("div_err", int'(div_if.div_err), int'(exp_err));
      chk("cur_div", int'(cur_div), m_cur);
      chk("div_ready", int'(div_if.div_ready), int'(!m_pend_v));
    end
    chk(at_pos ? "clk_out_pos" : "clk_out_neg", int'(clk_out), int'(hc_left > 0));
    if (hc_left > 0) hc_left--;
  endtask

  initial forever begin
    @(posedge clk_in);
    #1;
    sample(1'b1);
    @(negedge clk_in);
    #1;
    sample(1'b0);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic offer_once(input int v);
    div_if.div_in    = W'(v);
    div_if.div_valid = 1'b1;
    @(negedge clk_in);
    div_if.div_valid = 1'b0;
  endtask

  task automatic offer_hold(input int v);
    bit got;
    got = 1'b0;
    div_if.div_in    = W'(v);
    div_if.div_valid = 1'b1;
    for (int i = 0; i < 600 && !got; i++) begin
      if (div_if.div_ready) got = 1'b1;
      @(negedge clk_in);
    end
    div_if.div_valid = 1'b0;
    chk("offer_accept", int'(got), 1);
  endtask

  initial begin
    bit found;
    div_if.div_valid = 1'b0;
    div_if.div_in    = '0;
    repeat (3) @(negedge clk_in);
    en = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    wait_cycles(30);

    offer_once(1);
    wait_cycles(2);
    offer_once(0);
    wait_cycles(10);

    offer_hold(5);
    offer_hold(9);
    wait_cycles(40);

    wait_cycles(3);
    offer_hold(4);
    wait_cycles(20);

    offer_hold(6);
    wait_cycles(20);
    wait_cycles(2);
    en = 1'b0;
    wait_cycles(20);
    en = 1'b1;
    wait_cycles(20);

    offer_once(9);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_in);
      if (clk_out) found = 1'b1;
    end
    chk("wait_high", int'(found), 1);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    wait_cycles(30);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_in);
      rst              = ($urandom_range(0, 599) == 0);
      en               = ($urandom_range(0, 24) != 0);
      div_if.div_valid = ($urandom_range(0, 5) == 0);
      div_if.div_in    = ($urandom_range(0, 39) == 0) ? 8'd255 : 8'($urandom_range(0, 13));
    end

    @(negedge clk_in);
    rst              = 1'b0;
    en               = 1'b0;
    div_if.div_valid = 1'b0;
    wait_cycles(600);
    chk("tick_queue_drained", tq.size(), 0);
    chk("err_queue_drained", eq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
